regfile_sequencer: RTL

- Initiator-side controller for the 16-entry, 8-bit, two-read/one-write register file.
- Accepts one micro-instruction at a time over a valid/ready handshake.
- Drives the register file's read addresses and captures the returned operands.
- Computes a simple ALU result and issues a single write-back, then signals completion. It is the only writer of the register file in the datapath.

---
 rtl/regfile_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/regfile_sequencer.sv
// Initiator-side sequencer for a 16x8 two-read/one-write register file.
// Accepts one micro-instruction at a time, reads operands, runs a small ALU
// and issues a single write-back strobe together with a done pulse.
module regfile_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [1:0]            instr_op,
  input  logic [ADDR_WIDTH-1:0] instr_rd,
  input  logic [ADDR_WIDTH-1:0] instr_rs1,
  input  logic [ADDR_WIDTH-1:0] instr_rs2,
  input  logic [DATA_WIDTH-1:0] instr_imm,
  output logic [ADDR_WIDTH-1:0] readAddress1,
  output logic [ADDR_WIDTH-1:0] readAddress2,
  input  logic [DATA_WIDTH-1:0] readData1,
  input  logic [DATA_WIDTH-1:0] readData2,
  output logic [ADDR_WIDTH-1:0] writeAddress,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic                  writeEnable,
  output logic                  done,
  output logic                  carry
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  localparam logic [1:0] OP_LOADI = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;

  state_t                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] rs1_q, rs1_d;
  logic [ADDR_WIDTH-1:0] rs2_q, rs2_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  // result register: holds the LOADI immediate or the ALU result
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                  we_q, we_d;
  logic                  done_q, done_d;
  logic                  carry_q, carry_d;
  logic [DATA_WIDTH:0]   alu_sum, alu_diff;

  // Ready only in IDLE and never while reset is asserted.
  assign instr_ready  = (state_q == IDLE) && !rst;
  assign readAddress1 = rs1_q;
  assign readAddress2 = rs2_q;
  assign writeAddress = waddr_q;
  assign writeData    = result_q;
  // The register file lets a write win over its clear, so the strobe is
  // masked by reset even in the first cycle reset rises.
  assign writeEnable  = we_q && !rst;
  assign done         = done_q && !rst;
  assign carry        = carry_q;

  // Next-state and datapath: accept, operand capture, ALU, write-back.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    waddr_d  = waddr_q;
    carry_d  = carry_q;
    we_d     = 1'b0;
    done_d   = 1'b0;
    alu_sum  = {1'b0, a_q} + {1'b0, b_q};
    alu_diff = {1'b0, a_q} - {1'b0, b_q};
    case (state_q)
      IDLE: begin
        if (instr_valid && instr_ready) begin
          op_d  = instr_op;
          rd_d  = instr_rd;
          rs1_d = instr_rs1;
          rs2_d = instr_rs2;
          if (instr_op == OP_LOADI) begin
            // LOADI skips the operand stages and writes next cycle
            result_d = instr_imm;
            waddr_d  = instr_rd;
            we_d     = 1'b1;
            done_d   = 1'b1;
            state_d  = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        a_d     = readData1;
        b_d     = readData2;
        state_d = EXEC;
      end
      EXEC: begin
        case (op_q)
          OP_ADD: begin
            result_d = alu_sum[DATA_WIDTH-1:0];
            carry_d  = alu_sum[DATA_WIDTH];
          end
          OP_SUB: begin
            // top bit of the widened difference is the borrow (a < b)
            result_d = alu_diff[DATA_WIDTH-1:0];
            carry_d  = alu_diff[DATA_WIDTH];
          end
          default: result_d = a_q;
        endcase
        waddr_d = rd_q;
        we_d    = 1'b1;
        done_d  = 1'b1;
        state_d = WRITE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      waddr_q  <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      waddr_q  <= waddr_d;
      we_q     <= we_d;
      done_q   <= done_d;
      carry_q  <= carry_d;
    end
  end

endmodule
